pdp8_ram_arb: RTL and testbench

Two-port arbiter sharing the single-ported 32K×12 `pdp8_ram` between the CPU's memory port and the I/O subsystem's data-break (DMA) port. Sits between `pdp8`, `pdp8_io` and `pdp8_ram` in the FPGA top level, replacing the direct CPU-to-RAM connection. It sequences every access through a fixed three-state cycle, latches read data per requester, and returns a one-cycle acknowledge.

---
 rtl/pdp8_ram_arb.sv | 116 +++++++++++
 tb/tb_pdp8_ram_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_ram_arb.sv
// pdp8_ram_arb: shares the single-ported pdp8_ram between the CPU port and the data-break (DMA) port.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise DMA has fixed priority over the CPU.
module pdp8_ram_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [11:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic [14:0] dma_ma,
    input  logic [11:0] dma_wdata,
    input  logic        dma_read_req,
    input  logic        dma_write,
    output logic [11:0] dma_rdata,
    output logic        dma_done,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_data_out,
    input  logic [11:0] ram_data_in,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    logic        sel_dma;
    logic        op_wr;
    logic [11:0] cpu_rdata_q;
    logic [11:0] dma_rdata_q;

    logic        cpu_req;
    logic        dma_req;
    logic        grant_dma;
    logic        grant_wr;
    logic [14:0] grant_addr;
    logic [11:0] grant_wdata;

    assign cpu_req = cpu_rd | cpu_wr;
    assign dma_req = dma_read_req | dma_write;

`ifdef RAM_ARB_RR_EN
    logic last_dma;
    // On a tie the port that was not granted last wins.
    assign grant_dma = dma_req & (~cpu_req | ~last_dma);
`else
    assign grant_dma = dma_req;
`endif

    assign grant_wr    = grant_dma ? dma_write : cpu_wr;
    assign grant_addr  = grant_dma ? dma_ma    : cpu_addr;
    assign grant_wdata = grant_dma ? dma_wdata : cpu_wdata;

    // Read data is forwarded from the RAM during RESP so it is valid alongside the acknowledge.
    assign cpu_rdata = (state == RESP && !sel_dma && !op_wr) ? ram_data_in : cpu_rdata_q;
    assign dma_rdata = (state == RESP &&  sel_dma && !op_wr) ? ram_data_in : dma_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel_dma      <= 1'b0;
            op_wr        <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            ram_rd       <= 1'b0;
            ram_wr       <= 1'b0;
            cpu_ack      <= 1'b0;
            dma_done     <= 1'b0;
            dma_active   <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
`ifdef RAM_ARB_RR_EN
            last_dma     <= 1'b0;
`endif
        end else begin
            ram_rd   <= 1'b0;
            ram_wr   <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req | dma_req) begin
                        state        <= ACC;
                        sel_dma      <= grant_dma;
                        op_wr        <= grant_wr;
                        ram_addr     <= grant_addr;
                        ram_data_out <= grant_wdata;
                        ram_rd       <= ~grant_wr;
                        ram_wr       <= grant_wr;
                        dma_active   <= grant_dma;
`ifdef RAM_ARB_RR_EN
                        last_dma     <= grant_dma;
`endif
                    end
                end
                ACC: begin
                    state    <= RESP;
                    cpu_ack  <= ~sel_dma;
                    dma_done <= sel_dma;
                end
                RESP: begin
                    state      <= IDLE;
                    dma_active <= 1'b0;
                    if (!op_wr) begin
                        if (sel_dma) dma_rdata_q <= ram_data_in;
                        else         cpu_rdata_q <= ram_data_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdp8_ram_arb.sv
// Randomized bench for pdp8_ram_arb with a transaction-level model: each grant schedules its strobe,
// ack and read data at fixed offsets from the grant cycle; a model memory tracks RAM contents.
module tb_pdp8_ram_arb;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_rd, cpu_wr;
    logic [11:0] cpu_rdata;
    logic        cpu_ack;
    logic [14:0] dma_ma;
    logic [11:0] dma_wdata;
    logic        dma_read_req, dma_write;
    logic [11:0] dma_rdata;
    logic        dma_done;
    logic [14:0] ram_addr;
    logic [11:0] ram_data_out;
    logic [11:0] ram_data_in = '0;
    logic        ram_rd, ram_wr;
    logic        dma_active;

    always #5 clk = ~clk;

    pdp8_ram_arb dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_ma(dma_ma), .dma_wdata(dma_wdata), .dma_read_req(dma_read_req), .dma_write(dma_write),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .dma_active(dma_active)
    );

    // Power-up RAM contents are a fixed function of the address.
    function automatic logic [11:0] init_word(input logic [14:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd37 + 32'd1234;
        return t[11:0] ^ {a[2:0], a[14:6]};
    endfunction

    // Behavioural 32Kx12 RAM: read data appears the cycle after the read strobe.
    logic [11:0] mem_val [0:32767];
    bit          mem_w   [0:32767];
    always @(posedge clk) begin
        if (ram_wr) begin
            mem_val[ram_addr] <= ram_data_out;
            mem_w[ram_addr]   <= 1'b1;
        end
        if (ram_rd) ram_data_in <= mem_w[ram_addr] ? mem_val[ram_addr] : init_word(ram_addr);
    end

    typedef struct {
        int          ready;
        bit          wr;
        bit          both;
        logic [14:0] addr;
        logic [11:0] data;
    } req_t;

    req_t cpu_q[$], dma_q[$];
    req_t cpu_cur, dma_cur;
    bit   cpu_on, dma_on;
    int   cpu_drop, dma_drop;

    logic [11:0] shadow [int];

    bit          e_rd [MAXC], e_wr [MAXC], e_cack [MAXC], e_ddone [MAXC], e_act [MAXC];
    bit          ev_a_v [MAXC], ev_cr_v [MAXC], ev_dr_v [MAXC];
    logic [14:0] ev_a [MAXC];
    logic [11:0] ev_wd [MAXC], ev_cr [MAXC], ev_dr [MAXC];
    logic [14:0] x_addr;
    logic [11:0] x_wd, x_cr, x_dr;

    int c, free_at, hold_off, rst_until, rst_at;
    bit abort_cpu_wr, rand_on;
`ifdef RAM_ARB_RR_EN
    bit last_dma_m;
`endif
    int n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, c, got, exp);
    endtask

    function automatic logic [11:0] model_read(input logic [14:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
    endfunction

    function automatic req_t mk(input int ready, input bit wr, input bit both,
                                input logic [14:0] addr, input logic [11:0] data);
        req_t r;
        r.ready = ready; r.wr = wr; r.both = both; r.addr = addr; r.data = data;
        return r;
    endfunction

    function automatic logic [14:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 15'o00000;
            1:       return 15'o77777;
            2:       return 15'o00100;
            3:       return 15'o07777;
            default: return 15'($urandom_range(0, 7));
        endcase
    endfunction

    function automatic req_t rand_req(input int ready);
        bit wr;
        wr = 1'($urandom_range(0, 1));
        return mk(ready, wr, wr && ($urandom_range(0, 3) == 0), rand_addr(), 12'($urandom));
    endfunction

    task automatic step();
        req_t        r;
        bit          pick_dma;
        logic [11:0] v;
        @(negedge clk);
        if (ev_a_v[c])  begin x_addr = ev_a[c]; x_wd = ev_wd[c]; end
        if (ev_cr_v[c]) x_cr = ev_cr[c];
        if (ev_dr_v[c]) x_dr = ev_dr[c];

        chk("ram_rd",       32'(ram_rd),       32'(e_rd[c]));
        chk("ram_wr",       32'(ram_wr),       32'(e_wr[c]));
        chk("cpu_ack",      32'(cpu_ack),      32'(e_cack[c]));
        chk("dma_done",     32'(dma_done),     32'(e_ddone[c]));
        chk("dma_active",   32'(dma_active),   32'(e_act[c]));
        chk("ram_addr",     32'(ram_addr),     32'(x_addr));
        chk("ram_data_out", 32'(ram_data_out), 32'(x_wd));
        chk("cpu_rdata",    32'(cpu_rdata),    32'(x_cr));
        chk("dma_rdata",    32'(dma_rdata),    32'(x_dr));

        if (cpu_on && cpu_drop == c) cpu_on = 1'b0;
        if (dma_on && dma_drop == c) dma_on = 1'b0;

        if (c == rst_at) begin
            reset  = 1'b1;
            cpu_on = 1'b0;
            dma_on = 1'b0;
            for (int k = c + 1; k <= c + 3; k++) begin
                e_rd[k] = 0; e_wr[k] = 0; e_cack[k] = 0; e_ddone[k] = 0; e_act[k] = 0;
                ev_a_v[k] = 0; ev_cr_v[k] = 0; ev_dr_v[k] = 0;
            end
            ev_a_v[c+1]  = 1; ev_a[c+1] = '0; ev_wd[c+1] = '0;
            ev_cr_v[c+1] = 1; ev_cr[c+1] = '0;
            ev_dr_v[c+1] = 1; ev_dr[c+1] = '0;
`ifdef RAM_ARB_RR_EN
            last_dma_m = 1'b0;
`endif
            free_at  = c + 1;
            hold_off = c + 3;
        end else begin
            reset = (c < rst_until);
        end

        if (rand_on) begin
            if (!cpu_on && cpu_q.size() == 0 && $urandom_range(0, 2) == 0) cpu_q.push_back(rand_req(c));
            if (!dma_on && dma_q.size() == 0 && $urandom_range(0, 2) == 0) dma_q.push_back(rand_req(c));
        end
        if (!reset && c >= hold_off) begin
            if (!cpu_on && cpu_q.size() > 0 && cpu_q[0].ready <= c) begin cpu_cur = cpu_q.pop_front(); cpu_on = 1'b1; end
            if (!dma_on && dma_q.size() > 0 && dma_q[0].ready <= c) begin dma_cur = dma_q.pop_front(); dma_on = 1'b1; end
        end

        cpu_rd       = cpu_on && (!cpu_cur.wr || cpu_cur.both);
        cpu_wr       = cpu_on && cpu_cur.wr;
        cpu_addr     = cpu_on ? cpu_cur.addr : 15'($urandom);
        cpu_wdata    = cpu_on ? cpu_cur.data : 12'($urandom);
        dma_read_req = dma_on && (!dma_cur.wr || dma_cur.both);
        dma_write    = dma_on && dma_cur.wr;
        dma_ma       = dma_on ? dma_cur.addr : 15'($urandom);
        dma_wdata    = dma_on ? dma_cur.data : 12'($urandom);

        if (!reset && c >= free_at && (cpu_on || dma_on)) begin
`ifdef RAM_ARB_RR_EN
            pick_dma = dma_on && (!cpu_on || !last_dma_m);
            last_dma_m = pick_dma;
`else
            pick_dma = dma_on;
`endif
            r = pick_dma ? dma_cur : cpu_cur;
            e_rd[c+1] = !r.wr;
            e_wr[c+1] = r.wr;
            ev_a_v[c+1] = 1; ev_a[c+1] = r.addr; ev_wd[c+1] = r.data;
            e_act[c+1] = pick_dma;
            e_act[c+2] = pick_dma;
            if (pick_dma) begin e_ddone[c+2] = 1; dma_drop = c + 2; end
            else          begin e_cack[c+2]  = 1; cpu_drop = c + 2; end
            if (r.wr) begin
                shadow[int'(r.addr)] = r.data;
            end else begin
                v = model_read(r.addr);
                if (pick_dma) begin ev_dr_v[c+2] = 1; ev_dr[c+2] = v; end
                else          begin ev_cr_v[c+2] = 1; ev_cr[c+2] = v; end
            end
            free_at = c + 3;
            if (abort_cpu_wr && !pick_dma && r.wr) begin
                rst_at       = c + 1;
                abort_cpu_wr = 1'b0;
            end
        end
        c++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic settle();
        int k;
        k = 0;
        while ((cpu_on || dma_on || cpu_q.size() > 0 || dma_q.size() > 0 || c < free_at || rst_at >= c)
               && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) chk("settle_timeout", 32'd1, 32'd0);
        run(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", c);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] keep;
        reset = 1'b1;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_read_req = 0; dma_write = 0; dma_ma = '0; dma_wdata = '0;
        x_addr = '0; x_wd = '0; x_cr = '0; x_dr = '0;
        c = 0; rst_until = 3; free_at = 3; hold_off = 4; rst_at = -1;
        abort_cpu_wr = 0; rand_on = 0; cpu_on = 0; dma_on = 0;
        n_chk = 0; n_pass = 0;
`ifdef RAM_ARB_RR_EN
        last_dma_m = 1'b0;
`endif
        run(6);

        cpu_q.push_back(mk(c, 1, 0, 15'o00100, 12'o1234));
        settle();
        cpu_q.push_back(mk(c, 0, 0, 15'o00100, 12'o0000));
        settle();
        chk("cpu_read_back", 32'(cpu_rdata), 32'(12'o1234));

        cpu_q.push_back(mk(c, 1, 0, 15'o07777, 12'o4321));
        settle();
        dma_q.push_back(mk(c, 0, 0, 15'o07777, 12'o0000));
        settle();
        chk("dma_read_back", 32'(dma_rdata), 32'(12'o4321));
        chk("cpu_rdata_kept", 32'(cpu_rdata), 32'(12'o1234));

        cpu_q.push_back(mk(c, 0, 0, 15'o00100, 12'o0000));
        dma_q.push_back(mk(c, 1, 0, 15'o00100, 12'o5555));
        settle();
`ifdef RAM_ARB_RR_EN
        chk("tie_cpu_read", 32'(cpu_rdata), 32'(12'o1234));
`else
        chk("tie_cpu_read", 32'(cpu_rdata), 32'(12'o5555));
`endif

        keep = cpu_rdata;
        cpu_q.push_back(mk(c, 1, 1, 15'o00300, 12'o0077));
        settle();
        chk("rdwr_rdata_kept", 32'(cpu_rdata), 32'(keep));
        cpu_q.push_back(mk(c, 0, 0, 15'o00300, 12'o0000));
        settle();
        chk("rdwr_wrote", 32'(cpu_rdata), 32'(12'o0077));

        abort_cpu_wr = 1'b1;
        cpu_q.push_back(mk(c, 1, 0, 15'o00200, 12'o3333));
        settle();
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        cpu_q.push_back(mk(c, 0, 0, 15'o00200, 12'o0000));
        settle();
        chk("rst_write_kept", 32'(cpu_rdata), 32'(12'o3333));

        for (int i = 0; i < 2; i++) begin
            cpu_q.push_back(mk(c, 0, 0, 15'(i), 12'o0000));
            dma_q.push_back(mk(c, 1, 0, 15'(i + 4), 12'(i + 100)));
        end
        settle();

        rand_on = 1'b1;
        run(900);
        rand_on = 1'b0;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
